// File: rtl/sram_array_ctrl_pkg.sv
// Shared types and helpers for the sram_array_ctrl slice (package sram_array_pkg).
// The parity helper exists only when SRAM_ARRAY_PARITY_EN is defined.
package sram_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        WL_ON = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PRECH_CYCLES = 1;

    // Widest word the parity helper folds; narrower words are zero-padded.
    localparam int MAX_WIDTH = 64;

    function automatic logic merge_bit(input logic old_b, input logic new_b, input logic mask_b);
        return mask_b ? new_b : old_b;
    endfunction

`ifdef SRAM_ARRAY_PARITY_EN
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Request/response and strobe bundle between the memory stage and sram_array_ctrl.
// SRAM_ARRAY_PARITY_EN adds err_inject and rsp_perr.
interface sram_array_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only while idle, and rsp_valid is a one-cycle strobe with no backpressure.
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [WIDTH-1:0] req_wmask;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic [DEPTH-1:0] wl_o;
    logic             rd_pulse_o;
    logic             wr_pulse_o;
`ifdef SRAM_ARRAY_PARITY_EN
    logic             err_inject;
    logic             rsp_perr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, err_inject,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr,
        input  wl_o, rd_pulse_o, wr_pulse_o
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, err_inject,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr,
        output wl_o, rd_pulse_o, wr_pulse_o
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wl_o, rd_pulse_o, wr_pulse_o
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output wl_o, rd_pulse_o, wr_pulse_o
    );
`endif

endinterface

// File: rtl/sram_array_ctrl_word.sv
// sram_word: one storage word of the array, masked update on wl && commit, async clear.
// With SRAM_ARRAY_PARITY_EN it also keeps an even-parity bit over the merged data.
module sram_word
    import sram_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wl,
    input  logic             commit,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
`ifdef SRAM_ARRAY_PARITY_EN
    input  logic             inject,
    output logic             par,
`endif
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] merged;

    always_comb begin
        merged = '0;
        for (int b = 0; b < WIDTH; b++) begin
            merged[b] = merge_bit(q[b], wdata[b], wmask[b]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (wl && commit) begin
            q <= merged;
        end
    end

`ifdef SRAM_ARRAY_PARITY_EN
    logic [MAX_WIDTH-1:0] merged_pad;

    always_comb begin
        merged_pad = '0;
        merged_pad[WIDTH-1:0] = merged;
    end

    // inject deliberately corrupts the stored bit so a later read can flag it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (wl && commit) begin
            par <= even_parity(merged_pad) ^ inject;
        end
    end
`endif

endmodule

// File: rtl/sram_array_ctrl.sv
// DEPTH x WIDTH behavioural SRAM plus its precharge / word-line / pulse sequencer.
// Optional parity storage and checking under SRAM_ARRAY_PARITY_EN.
module sram_array_ctrl
    import sram_array_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int PULSE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_array_ctrl_if.slave bus,
    output state_t           state_dbg
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (PULSE_CYCLES > PRECH_CYCLES) ? PULSE_CYCLES : PRECH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q, wmask_q;
    logic [WIDTH-1:0] rdata_q;
    logic             accept, commit, in_range;
    logic [DEPTH-1:0] wl;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] rd_word;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign commit   = (state_q == WL_ON) && (state_d == DONE);
    assign in_range = 32'(addr_q) < DEPTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The phase counter restarts on every state change, so each phase counts from zero.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = PRECH;
            PRECH:   if (cnt_q == CW'(PRECH_CYCLES - 1)) state_d = WL_ON;
            WL_ON:   if (cnt_q == CW'(PULSE_CYCLES - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        wl             = '0;
        bus.req_ready  = (state_q == IDLE);
        bus.rsp_valid  = (state_q == DONE);
        bus.rsp_err    = (state_q == DONE) && !in_range;
        bus.rd_pulse_o = (state_q == WL_ON) && !we_q;
        bus.wr_pulse_o = (state_q == WL_ON) && we_q;
        for (int i = 0; i < DEPTH; i++) begin
            wl[i] = (state_q == WL_ON) && (addr_q == AW'(i));
        end
    end

    assign bus.wl_o      = wl;
    assign bus.rsp_rdata = rdata_q;
    assign state_dbg     = state_q;

    // Request fields are captured at accept; the requester may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
            if (commit && !we_q) begin
                rdata_q <= in_range ? rd_word : '0;
            end
        end
    end

`ifdef SRAM_ARRAY_PARITY_EN
    logic                 inject_q, perr_q, rd_par;
    logic [DEPTH-1:0]     par_q;
    logic [MAX_WIDTH-1:0] rd_pad;

    always_comb begin
        rd_word = '0;
        rd_par  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == AW'(i)) begin
                rd_word = word_q[i];
                rd_par  = par_q[i];
            end
        end
        rd_pad = '0;
        rd_pad[WIDTH-1:0] = rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inject_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (accept) inject_q <= bus.err_inject;
            if (commit) perr_q <= !we_q && in_range && (even_parity(rd_pad) != rd_par);
        end
    end

    assign bus.rsp_perr = (state_q == DONE) && perr_q;
`else
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == AW'(i)) rd_word = word_q[i];
        end
    end
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        sram_word #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .rst    (rst),
            .wl     (wl[i]),
            .commit (commit && we_q),
            .wdata  (wdata_q),
            .wmask  (wmask_q),
`ifdef SRAM_ARRAY_PARITY_EN
            .inject (inject_q),
            .par    (par_q[i]),
`endif
            .q      (word_q[i])
        );
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl (DEPTH=10 so out-of-range addresses exist).
// Reference model: a plain word array updated bit by bit from the access rules.
module tb_sram_array_ctrl;
    import sram_array_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 10;
    localparam int PULSE = 2;
    localparam int AW    = 4;
    localparam int LAT   = PULSE + 2;  // edges counted from the accepting edge as edge 1

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;
    int     n_checks = 0;
    int     n_fail   = 0;

    sram_array_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sram_array_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PULSE_CYCLES(PULSE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic             par_mem [DEPTH];
    logic [WIDTH-1:0] last_rd;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            par_mem[i] = 1'b0;
        end
        last_rd = '0;
    endtask

    task automatic model_op(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                            input logic [WIDTH-1:0] wm, input logic inj,
                            output logic [WIDTH-1:0] rd, output logic err, output logic perr);
        err  = (int'(addr) >= DEPTH);
        perr = 1'b0;
        if (we) begin
            if (!err) begin
                for (int b = 0; b < WIDTH; b++) if (wm[b]) mem[addr][b] = wd[b];
                par_mem[addr] = (^mem[addr]) ^ inj;
            end
        end else begin
            last_rd = err ? '0 : mem[addr];
            perr    = !err && (par_mem[addr] != ^mem[addr]);
        end
        rd = last_rd;
    endtask

    // ---------------- driver ----------------
    task automatic drive_req(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                             input logic [WIDTH-1:0] wm, input logic inj);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
`ifdef SRAM_ARRAY_PARITY_EN
        bus.err_inject = inj;
`else
        if (inj) bus.req_wmask = wm;
`endif
    endtask

    task automatic do_op(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                         input logic [WIDTH-1:0] wm, input logic inj,
                         output int lat, output logic [WIDTH-1:0] rd, output logic err, output logic perr,
                         output int pulse_cyc, output int wl_bad, output logic valid_after);
        int               guard;
        logic [DEPTH-1:0] exp_wl;
        exp_wl = (int'(addr) < DEPTH) ? (DEPTH'(1) << addr) : '0;
        @(negedge clk);
        drive_req(we, addr, wd, wm, inj);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom_range(0, 15));
        bus.req_wdata = WIDTH'($urandom);
        bus.req_wmask = WIDTH'($urandom);
        lat = 1; pulse_cyc = 0; wl_bad = 0; rd = '0; err = 1'b0; perr = 1'b0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rd_pulse_o || bus.wr_pulse_o) begin
                pulse_cyc++;
                if (bus.wl_o !== exp_wl) wl_bad++;
                if (bus.wr_pulse_o !== we || bus.rd_pulse_o !== !we) wl_bad++;
            end else if (bus.wl_o !== '0) begin
                wl_bad++;
            end
            if (bus.rsp_valid) break;
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
`ifdef SRAM_ARRAY_PARITY_EN
        perr = bus.rsp_perr;
`endif
        @(posedge clk);
        #1;
        valid_after = bus.rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_checks++; if (bus.wl_o !== '0) begin n_fail++; $display("FAIL reset_wl_o: got %h want 0", bus.wl_o); end
        n_checks++; if (bus.rd_pulse_o !== 1'b0 || bus.wr_pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got rd=%b wr=%b want 0 0", bus.rd_pulse_o, bus.wr_pulse_o); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        rst = 1'b0;
        model_reset();
        do_op(1'b0, 4'd5, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd5, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL reset_read_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL reset_read_data: got %h want %h", rd, erd); end
        n_checks++; if (va !== 1'b0) begin n_fail++; $display("FAIL reset_read_valid_width: rsp_valid still %b want 0", va); end
    endtask

    task automatic test_write_read();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr;
        do_op(1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0, erd, eerr, eperr);
        n_checks++; if (pc !== PULSE || wb !== 0) begin n_fail++; $display("FAIL wr_strobes: got %0d pulse cycles %0d bad wl, want %0d and 0", pc, wb, PULSE); end
        n_checks++; if (err !== 1'b0 || lat !== LAT) begin n_fail++; $display("FAIL wr_rsp: got err=%b lat=%0d want 0 %0d", err, lat, LAT); end
        do_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", rd); end
        n_checks++; if (pc !== PULSE || wb !== 0 || err !== eerr) begin n_fail++; $display("FAIL rd_strobes: got %0d pulse %0d bad err=%b want %0d 0 0", pc, wb, err, PULSE); end
    endtask

    task automatic test_partial_mask();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr;
        do_op(1'b1, 4'd3, 8'h0F, 8'h0F, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd3, 8'h0F, 8'h0F, 1'b0, erd, eerr, eperr);
        do_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (rd !== 8'hAF) begin n_fail++; $display("FAIL partial_mask: got %h want af", rd); end
        // a zero mask must leave the word alone but still complete
        do_op(1'b1, 4'd3, 8'h55, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd3, 8'h55, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL zero_mask_rsp: got latency %0d want %0d", lat, LAT); end
        do_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL zero_mask_data: got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd, wd, wm;
        logic err, perr, va, eerr, eperr, we, inj;
        logic [AW-1:0] addr;
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 15));
            wd   = WIDTH'($urandom);
            wm   = (n % 4 == 0) ? 8'hFF : WIDTH'($urandom);
`ifdef SRAM_ARRAY_PARITY_EN
            inj  = 1'($urandom_range(0, 1));
`else
            inj  = 1'b0;
`endif
            do_op(we, addr, wd, wm, inj, lat, rd, err, perr, pc, wb, va);
            model_op(we, addr, wd, wm, inj, erd, eerr, eperr);
            n_checks++; if (rd !== erd || err !== eerr || perr !== eperr) begin n_fail++; $display("FAIL rand_rsp[%0d]: got rd=%h err=%b perr=%b want %h %b %b", n, rd, err, perr, erd, eerr, eperr); end
            n_checks++; if (lat !== LAT || pc !== PULSE || wb !== 0 || va !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d pulse=%0d badwl=%0d va=%b want %0d %0d 0 0", n, lat, pc, wb, va, LAT, PULSE); end
        end
    endtask

    task automatic test_out_of_range();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr;
        do_op(1'b1, 4'd12, 8'h5A, 8'hFF, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd12, 8'h5A, 8'hFF, 1'b0, erd, eerr, eperr);
        n_checks++; if (err !== 1'b1 || lat !== LAT || pc !== PULSE || wb !== 0) begin n_fail++; $display("FAIL oor_write: got err=%b lat=%0d pulse=%0d badwl=%0d want 1 %0d %0d 0", err, lat, pc, wb, LAT, PULSE); end
        do_op(1'b0, 4'd12, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd12, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (err !== 1'b1 || rd !== 8'h00) begin n_fail++; $display("FAIL oor_read: got err=%b rd=%h want 1 00", err, rd); end
        for (int a = 0; a < DEPTH; a++) begin
            do_op(1'b0, AW'(a), 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
            model_op(1'b0, AW'(a), 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
            n_checks++; if (rd !== erd || err !== 1'b0) begin n_fail++; $display("FAIL oor_array_scan[%0d]: got %h err=%b want %h 0", a, rd, err, erd); end
        end
    endtask

    task automatic test_back_to_back();
        logic             we_a [5];
        logic [AW-1:0]    ad_a [5];
        logic [WIDTH-1:0] wd_a [5];
        logic [WIDTH-1:0] wm_a [5];
        logic [WIDTH-1:0] exp_q [$];
        logic             exp_err_q [$];
        int               acc_cyc [$];
        logic [WIDTH-1:0] erd, got_exp;
        logic             eerr, eperr, got_err;
        int               cyc, idx, n_rsp;
        for (int i = 0; i < 5; i++) begin
            we_a[i] = (i % 2 == 0);
            ad_a[i] = (i < 4) ? 4'd7 : 4'd11;
            wd_a[i] = WIDTH'($urandom);
            wm_a[i] = WIDTH'($urandom);
        end
        cyc = 0; idx = 0; n_rsp = 0;
        @(negedge clk);
        drive_req(we_a[0], ad_a[0], wd_a[0], wm_a[0], 1'b0);
        while (n_rsp < 5 && cyc < 100) begin
            if (bus.rsp_valid) begin
                got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                got_err = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'bx;
                n_checks++; if (bus.rsp_rdata !== got_exp || bus.rsp_err !== got_err) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got rd=%h err=%b want %h %b", n_rsp, bus.rsp_rdata, bus.rsp_err, got_exp, got_err); end
                n_rsp++;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc.push_back(cyc);
                model_op(we_a[idx], ad_a[idx], wd_a[idx], wm_a[idx], 1'b0, erd, eerr, eperr);
                exp_q.push_back(erd);
                exp_err_q.push_back(eerr);
                idx++;
                @(posedge clk);
                #1;
                if (idx < 5) drive_req(we_a[idx], ad_a[idx], wd_a[idx], wm_a[idx], 1'b0);
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = 1'b0;
        n_checks++; if (n_rsp !== 5) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 5", n_rsp); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++; if (acc_cyc[i] - acc_cyc[i-1] !== PULSE + 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], PULSE + 3); end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, pc, wb, guard;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr, saw_valid;
        @(negedge clk);
        drive_req(1'b1, 4'd1, 8'hFF, 8'hFF, 1'b0);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.wr_pulse_o && guard < 10) begin @(posedge clk); #1; guard++; end
        n_checks++; if (bus.wr_pulse_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_reach_wl: got wr_pulse %b want 1", bus.wr_pulse_o); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.wr_pulse_o !== 1'b0 || bus.wl_o !== '0) begin n_fail++; $display("FAIL mid_reset_strobes: got wr=%b wl=%h want 0 0", bus.wr_pulse_o, bus.wl_o); end
        saw_valid = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid) saw_valid = 1'b1; end
        rst = 1'b0;
        model_reset();
        repeat (6) begin @(negedge clk); if (bus.rsp_valid) saw_valid = 1'b1; end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_rsp: got rsp_valid seen %b want 0", saw_valid); end
        do_op(1'b0, 4'd1, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd1, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (rd !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_read: got %h err=%b want 00 0", rd, err); end
    endtask

`ifdef SRAM_ARRAY_PARITY_EN
    task automatic test_parity();
        int lat, pc, wb;
        logic [WIDTH-1:0] rd, erd;
        logic err, perr, va, eerr, eperr;
        do_op(1'b1, 4'd2, 8'h3C, 8'hFF, 1'b1, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd2, 8'h3C, 8'hFF, 1'b1, erd, eerr, eperr);
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL parity_write_perr: got %b want 0", perr); end
        do_op(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (perr !== 1'b1 || rd !== 8'h3C) begin n_fail++; $display("FAIL parity_injected: got perr=%b rd=%h want 1 3c", perr, rd); end
        do_op(1'b1, 4'd2, 8'h3C, 8'hFF, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b1, 4'd2, 8'h3C, 8'hFF, 1'b0, erd, eerr, eperr);
        do_op(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, lat, rd, err, perr, pc, wb, va);
        model_op(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, erd, eerr, eperr);
        n_checks++; if (perr !== 1'b0 || rd !== 8'h3C) begin n_fail++; $display("FAIL parity_clean: got perr=%b rd=%h want 0 3c", perr, rd); end
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
`ifdef SRAM_ARRAY_PARITY_EN
        bus.err_inject = 1'b0;
`endif
        model_reset();
        test_reset();
        test_write_read();
        test_partial_mask();
        test_random();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_write();
`ifdef SRAM_ARRAY_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
- Parametrised, clocked successor to the single 6T cell: a DEPTH x WIDTH behavioural SRAM macro model plus its access sequencer.
- Accepts one read or write per request over a valid/ready handshake.
- Sequences precharge, word-line and read/write pulse phases in clock cycles, and returns read data or a write acknowledge.
- Sits between the core's memory-stage logic and the array; exposes WL and pulse strobes for analog correlation.

Parameters:
- WIDTH, 8, data bits per word (>=1).
- DEPTH, 16, number of words (>=2, need not be a power of two).
- PULSE_CYCLES, 2, cycles the word line and read/write pulse stay asserted (>=1).
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  WIDTH  write data.
- req_wmask  in  WIDTH  per-bit write enable; 1 = update bit.
- rsp_valid  out  1  one-cycle completion strobe, for reads and writes.
- rsp_rdata  out  WIDTH  read data; holds last read value.
- rsp_err  out  1  valid with rsp_valid: address >= DEPTH.
- wl_o  out  DEPTH  one-hot word line; all-zero outside WL_ON.
- rd_pulse_o  out  1  read pulse, high during WL_ON of a read.
- wr_pulse_o  out  1  write pulse, high during WL_ON of a write.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; pulse counter cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wl_o=0, rd_pulse_o=0, wr_pulse_o=0.
  - Every array word cleared to 0 (cell power-up state I=0).
- FSM states: IDLE -> PRECH -> WL_ON -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch we/addr/wdata/wmask, then go to PRECH.
- PRECH:
  - One cycle; all strobes low; go to WL_ON.
- WL_ON:
  - Lasts exactly PULSE_CYCLES cycles.
  - wl_o[addr]=1 (all-zero if addr >= DEPTH).
  - rd_pulse_o or wr_pulse_o high per latched we.
  - Array is not modified while in WL_ON.
- WL_ON -> DONE edge (falling edge of the pulse):
  - Write: word <= (word & ~mask) | (wdata & mask).
  - Read: rsp_rdata <= word.
- DONE:
  - rsp_valid=1 for exactly one cycle; go to IDLE.
- Latency and throughput:
  - rsp_valid rises PULSE_CYCLES+2 edges after the accepting edge (default 4).
  - One operation per PULSE_CYCLES+3 cycles; requests are never queued.
- Inputs sampled outside IDLE are ignored; req_* may change freely after acceptance.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped; read returns rsp_rdata=0.
  - rsp_err=1 with rsp_valid; the full latency still applies.
- Write with wmask=0: no array change; rsp_valid still pulses.
- Read after write to the same address: returns the new data (the commit precedes the next accept).
- rst asserted mid-operation: operation aborted, no partial write, strobes drop immediately, and no rsp_valid is issued for the aborted request.

Optional Feature:
- Macro: SRAM_ARRAY_PARITY_EN.
- With macro defined:
  - Each word stores one extra even-parity bit over the merged (post-mask) data at commit; reset clears it to 0.
  - Extra input err_inject (1 bit), sampled at accept; inverts the stored parity bit of that write.
  - Extra output rsp_perr (1 bit), valid with rsp_valid on reads: stored parity != recomputed parity; 0 for writes and out-of-range reads.
- Without macro: no extra storage or ports; behaviour identical otherwise.

Decomposition:
- Package sram_array_pkg:
  - state enum (IDLE, PRECH, WL_ON, DONE).
  - PRECH_CYCLES=1 constant.
  - Function for the masked merge.
  - Function for parity (when enabled).
- Sub-module sram_word: one WIDTH(+parity) storage word with wl, commit strobe, wdata, wmask and async clear; generated DEPTH times.

Test Plan:
- Reset then idle: rst pulse -> all outputs at reset values, req_ready=1; reading addr 5 returns 0x00 with rsp_valid exactly 4 edges after accept.
- Write/read: write addr 3 = 0xA5, mask 0xFF; read addr 3 -> rsp_rdata=0xA5, rsp_err=0; wl_o=0x0008 for exactly 2 cycles during each op.
- Partial mask: addr 3 = 0xA5, write 0x0F with mask 0x0F -> read returns 0xAF.
- Busy/out-of-range: hold req_valid high with back-to-back requests -> accepts exactly 5 cycles apart. With DEPTH=10, write addr 12 then read 12 -> rsp_err=1, rsp_rdata=0x00, no array word changed.
- Reset mid-write: assert rst during WL_ON of a write of 0xFF to addr 1 -> no rsp_valid, wr_pulse_o drops asynchronously, later read of addr 1 returns 0x00.
- Parity (SRAM_ARRAY_PARITY_EN): write 0x3C to addr 2 with err_inject=1, read -> rsp_perr=1 and rsp_rdata=0x3C; clean rewrite then read -> rsp_perr=0.
